// File: rtl/ama_riscv_branch_resolve.sv
// Execute-stage branch resolver: evaluates the branch outcome from comparator
// flags, detects mispredictions, and sequences the fetch redirect and flush.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accepting branches; correct predictions stay here
// REDIRECT | holding redirect_pc for fetch until redirect_ready handshake
// FLUSH    | post-handshake flush, FLUSH_CYC cycles via down-counter
module ama_riscv_branch_resolve #(
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        op_a_eq_b,
  input  logic        op_a_lt_b,
  output logic        op_uns,
  output logic        ex_ready,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        res_valid,
  output logic        res_taken,
  output logic        res_illegal,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        res_valid_q, res_valid_d;
  logic        res_taken_q, res_taken_d;
  logic        res_illegal_q, res_illegal_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic        taken;
  logic        illegal;
  logic        accept;
  logic        mispred;
  logic [31:0] corr_pc;

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE
  assign op_uns = ex_funct3[1];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (ex_funct3)
      3'b000:          taken = op_a_eq_b;
      3'b001:          taken = !op_a_eq_b;
      3'b100, 3'b110:  taken = op_a_lt_b;
      3'b101, 3'b111:  taken = !op_a_lt_b;
      default:         illegal = 1'b1;
    endcase
  end

  assign accept  = ex_valid & ex_branch & (state_q == IDLE);
  assign mispred = accept & (taken != ex_pred_taken);
  assign corr_pc = taken ? ex_target : (ex_pc + 32'd4);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    res_valid_d   = accept;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (accept) begin
      res_taken_d  = taken;
      res_illegal_d = illegal;
      branch_cnt_d = branch_cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d       = REDIRECT;
          redirect_pc_d = corr_pc;
          mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      redirect_pc_q <= 32'd0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign ex_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q != IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_illegal    = res_illegal_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_ama_riscv_branch_resolve.sv
// Scoreboard bench for ama_riscv_branch_resolve: ISA-level branch model drives
// expectations into queues, a negedge monitor pops and compares.
module tb_ama_riscv_branch_resolve;

  localparam int unsigned FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_branch = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_target = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic        op_a_eq_b;
  logic        op_a_lt_b;
  logic        op_uns;
  logic        ex_ready;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        res_valid;
  logic        res_taken;
  logic        res_illegal;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  // operands behind the comparator the resolver steers through op_uns
  logic [31:0] cmp_a = 32'd0;
  logic [31:0] cmp_b = 32'd0;
  assign op_a_eq_b = (cmp_a == cmp_b);
  assign op_a_lt_b = op_uns ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  ama_riscv_branch_resolve #(.FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .op_a_eq_b(op_a_eq_b), .op_a_lt_b(op_a_lt_b), .op_uns(op_uns),
    .ex_ready(ex_ready), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
    .res_illegal(res_illegal), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } res_exp_t;

  res_exp_t    res_q[$];
  logic [31:0] rdr_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_b = 32'd0;
  logic [31:0] exp_m = 32'd0;
  logic        rr_rand = 1'b0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (unexpected event or timeout at cycle %0d)", name, cyc);
  endtask

  // RISC-V conditional branch semantics on the raw operands
  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic set_inputs(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid      = 1'b1;
    ex_branch     = 1'b1;
    ex_funct3     = f3;
    cmp_a         = a;
    cmp_b         = b;
    ex_pred_taken = pred;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  // Presents a branch, holds it until accepted, records expectations; returns
  // one tick after the accepting edge with the inputs dropped.
  task automatic present_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    logic     tk, ill, acc;
    res_exp_t e;
    set_inputs(f3, a, b, pred, pc, tgt);
    tk  = model_taken(f3, a, b);
    ill = (f3 == 3'd2) || (f3 == 3'd3);
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (i == 0) check("op_uns", 32'(op_uns), 32'(f3[1]));
      if (ex_ready && !rst) begin
        acc   = 1'b1;
        exp_b = exp_b + 32'd1;
        if (tk != pred) begin
          exp_m = exp_m + 32'd1;
          rdr_q.push_back(tk ? tgt : pc + 32'd4);
        end
        e.taken   = tk;
        e.illegal = ill;
        e.bcnt    = exp_b;
        e.mcnt    = exp_m;
        res_q.push_back(e);
      end
    end
    if (!acc) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ex_ready) done = 1'b1;
    end
    if (!done) fail_now("idle_timeout");
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) redirect_ready = 1'($urandom_range(0, 1));
  end

  // monitor: result pulses, redirect stability/handshake, flush length
  int redir_len = 0;
  int flush_len = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      redir_len = 0;
      flush_len = 0;
    end else begin
      check("ex_ready_vs_flush", 32'(ex_ready), 32'(!flush));
      if (res_valid) begin
        if (res_q.size() == 0) fail_now("spurious_res_valid");
        else begin
          res_exp_t e;
          e = res_q.pop_front();
          check("res_taken", 32'(res_taken), 32'(e.taken));
          check("res_illegal", 32'(res_illegal), 32'(e.illegal));
          check("branch_cnt", branch_cnt, e.bcnt);
          check("mispred_cnt", mispred_cnt, e.mcnt);
        end
      end
      if (redirect_valid) begin
        if (rdr_q.size() == 0) fail_now("spurious_redirect");
        else begin
          check("redirect_pc", redirect_pc, rdr_q[0]);
          if (redirect_ready) void'(rdr_q.pop_front());
        end
      end
      if (flush) begin
        flush_len++;
        if (redirect_valid) redir_len++;
      end else if (flush_len > 0) begin
        check("flush_length", 32'(flush_len), 32'(redir_len + int'(FLUSH_CYC)));
        flush_len = 0;
        redir_len = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    #2 rst = 1'b1;
    #1;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_taken", 32'(res_taken), 32'd0);
    check("rst_res_illegal", 32'(res_illegal), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);

    // BEQ mispredict with redirect_ready held high
    @(posedge clk); #1;
    redirect_ready = 1'b1;
    present_branch(3'd0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h200);
    @(negedge clk);
    check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
    check("beq_flush", 32'(flush), 32'd1);
    check("beq_ex_ready", 32'(ex_ready), 32'd0);
    check("beq_redirect_pc", redirect_pc, 32'h200);
    wait_idle();
    check("beq_mispred_cnt", mispred_cnt, 32'd1);
    @(posedge clk); #1;

    // BGEU correctly predicted taken
    present_branch(3'd7, 32'd1, 32'd0, 1'b1, 32'h300, 32'h400);
    @(negedge clk);
    check("bgeu_res_valid", 32'(res_valid), 32'd1);
    check("bgeu_res_taken", 32'(res_taken), 32'd1);
    check("bgeu_no_redirect", 32'(redirect_valid), 32'd0);
    check("bgeu_branch_cnt", branch_cnt, 32'd2);
    @(posedge clk); #1;

    // BLT not taken at top of address space: pc+4 wraps
    present_branch(3'd4, 32'd5, 32'd1, 1'b1, 32'hFFFF_FFFC, 32'h40);
    @(negedge clk);
    check("blt_wrap_redirect_pc", redirect_pc, 32'h0000_0000);
    wait_idle();
    @(posedge clk); #1;

    // redirect stalled 5 cycles; branch presented meanwhile must wait
    redirect_ready = 1'b0;
    present_branch(3'd1, 32'd1, 32'd2, 1'b0, 32'h500, 32'h600);
    set_inputs(3'd0, 32'd7, 32'd7, 1'b1, 32'h700, 32'h800);
    repeat (5) begin
      @(negedge clk);
      check("stall_redirect_valid", 32'(redirect_valid), 32'd1);
      check("stall_redirect_pc", redirect_pc, 32'h600);
      check("stall_branch_cnt", branch_cnt, exp_b);
    end
    @(posedge clk); #1;
    redirect_ready = 1'b1;
    present_branch(3'd0, 32'd7, 32'd7, 1'b1, 32'h700, 32'h800);
    wait_idle();
    @(posedge clk); #1;

    // reserved funct3
    present_branch(3'd2, 32'd3, 32'd3, 1'b0, 32'h900, 32'hA00);
    @(negedge clk);
    check("ill_res_illegal", 32'(res_illegal), 32'd1);
    check("ill_res_taken", 32'(res_taken), 32'd0);
    check("ill_no_redirect", 32'(redirect_valid), 32'd0);
    @(posedge clk); #1;

    // back-to-back correct predictions, one per cycle
    c0 = cyc;
    present_branch(3'd0, 32'd1, 32'd1, 1'b1, 32'h10, 32'h20);
    present_branch(3'd1, 32'd1, 32'd1, 1'b0, 32'h14, 32'h24);
    present_branch(3'd6, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'h18, 32'h28);
    present_branch(3'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'h1C, 32'h2C);
    check("b2b_cycles", 32'(cyc - c0), 32'd4);
    @(negedge clk);
    check("b2b_branch_cnt", branch_cnt, exp_b);
    @(posedge clk); #1;

    // reset in the second FLUSH cycle (last result was taken)
    present_branch(3'd0, 32'd3, 32'd3, 1'b0, 32'hB00, 32'hC00);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (flush && !redirect_valid) seen = 1'b1;
      end
      if (!seen) fail_now("flush_wait_timeout");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_res_taken", 32'(res_taken), 32'd0);
    check("arst_res_illegal", 32'(res_illegal), 32'd0);
    check("arst_redirect_pc", redirect_pc, 32'd0);
    check("arst_branch_cnt", branch_cnt, 32'd0);
    check("arst_mispred_cnt", mispred_cnt, 32'd0);
    exp_b = 32'd0;
    exp_m = 32'd0;
    res_q.delete();
    rdr_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("arst_ex_ready", 32'(ex_ready), 32'd1);
    check("arst_flush_after", 32'(flush), 32'd0);
    @(posedge clk); #1;

    // randomized traffic with random redirect_ready, bubbles in between
    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int bub;
      bub = $urandom_range(0, 2);
      for (int k = 0; k < bub; k++) begin
        case ($urandom_range(0, 2))
          0: begin ex_valid = 1'b1; ex_branch = 1'b0; end
          1: begin ex_valid = 1'b0; ex_branch = 1'b1; end
          default: begin ex_valid = 1'b0; ex_branch = 1'b0; end
        endcase
        ex_funct3 = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
      end
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
      present_branch(3'($urandom_range(0, 7)), pick_op(), pick_op(), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
                     $urandom() & 32'hFFFF_FFFC);
    end
    rr_rand = 1'b0;
    redirect_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("end_res_queue_empty", 32'(res_q.size()), 32'd0);
    check("end_rdr_queue_empty", 32'(rdr_q.size()), 32'd0);
    check("end_branch_cnt", branch_cnt, exp_b);
    check("end_mispred_cnt", mispred_cnt, exp_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ama_riscv_branch_resolve.md
AMA_RISCV_BRANCH_RESOLVE -- requirements
Module: ama_riscv_branch_resolve

Interface
REQ-001 Parameter FLUSH_CYC, default 2: number of flush cycles after a redirect handshake, legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ex_valid  input  1  execute-stage instruction valid.
REQ-005 ex_branch  input  1  the execute-stage instruction is a conditional branch.
REQ-006 ex_funct3  input  3  branch funct3 field.
REQ-007 ex_pc  input  32  branch PC.
REQ-008 ex_target  input  32  computed branch target.
REQ-009 ex_pred_taken  input  1  fetch-stage prediction for this branch.
REQ-010 op_a_eq_b  input  1  equality flag from the branch comparator.
REQ-011 op_a_lt_b  input  1  less-than flag from the branch comparator.
REQ-012 op_uns  output  1  unsigned-compare select driven back to the comparator.
REQ-013 ex_ready  output  1  resolver can accept a branch this cycle.
REQ-014 redirect_valid  output  1  fetch redirect request.
REQ-015 redirect_ready  input  1  fetch accepts the redirect.
REQ-016 redirect_pc  output  32  corrected fetch PC.
REQ-017 flush  output  1  kill younger in-flight instructions.
REQ-018 res_valid  output  1  one-cycle pulse marking a resolved branch.
REQ-019 res_taken  output  1  actual outcome of the resolved branch.
REQ-020 res_illegal  output  1  reserved funct3 (010/011) was resolved.
REQ-021 branch_cnt  output  32  count of accepted branches.
REQ-022 mispred_cnt  output  32  count of mispredicted branches.

Function
REQ-023 op_uns SHALL be combinational and equal ex_funct3[1].
REQ-024 Outcome SHALL be computed as follows:
- 000 -> eq
- 001 -> !eq
- 100 or 110 -> lt
- 101 or 111 -> !lt
- 010 or 011 -> not taken, with an illegal flag.
REQ-025 Accept SHALL be defined as ex_valid & ex_branch & ex_ready; without an accept, no state or counter changes.
REQ-026 ex_ready SHALL be 1 only in state IDLE; upstream holds its inputs while ex_ready=0.
REQ-027 Mispredict SHALL be defined as an accepted branch whose outcome differs from ex_pred_taken; an illegal funct3 compares as not taken.
REQ-028 Corrected PC SHALL be ex_target when taken, else ex_pc+4 (modulo 2^32, so 0xFFFFFFFC+4 gives 0x00000000).
REQ-029 res_valid, res_taken and res_illegal SHALL register on accept with 1-cycle latency; res_valid SHALL be 0 otherwise; res_taken and res_illegal SHALL hold their last value.
REQ-030 The state machine SHALL have the states IDLE, REDIRECT and FLUSH.
REQ-031 IDLE SHALL go to REDIRECT on a mispredicting accept; redirect_pc SHALL be registered the same edge.
REQ-032 REDIRECT:
- redirect_valid=1 and flush=1
- redirect_pc SHALL stay stable until redirect_ready=1
- on the handshake edge, go to FLUSH with a down-counter loaded to FLUSH_CYC-1.
REQ-033 FLUSH:
- flush=1 and redirect_valid=0
- the counter decrements each cycle
- at count 0, go to IDLE on the next edge.
REQ-034 Total flush duration SHALL be the REDIRECT cycles plus exactly FLUSH_CYC cycles.
REQ-035 A correctly predicted accept SHALL stay in IDLE with no redirect and no flush.
REQ-036 branch_cnt SHALL increment on every accept.
REQ-037 mispred_cnt SHALL increment on every mispredicting accept.
REQ-038 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-039 Back-to-back correct branches SHALL be accepted every cycle at full throughput.
REQ-040 redirect_ready=1 while not in REDIRECT SHALL be ignored.

Reset
REQ-041 On rst=1 (asynchronous), the block SHALL immediately:
- go to state IDLE with the flush counter at 0
- drive redirect_valid, flush, res_valid, res_taken and res_illegal to 0
- clear redirect_pc, branch_cnt and mispred_cnt to 0
- drive ex_ready=1 after release.
REQ-042 A reset asserted in REDIRECT or FLUSH SHALL abort the redirect with no handshake and no further flush cycles.

Verification
REQ-043 BEQ, eq=1, pred=0, pc=0x100, target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200, flush=1, ex_ready=0; with redirect_ready=1 held, flush SHALL stay high 1+2 cycles, then IDLE; mispred_cnt=1.
REQ-044 BGEU, lt=0, pred=1 -> no redirect, res_valid pulse with res_taken=1, branch_cnt+1, op_uns=1.
REQ-045 BLT not taken, pred=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000.
REQ-046 Mispredict with redirect_ready low for 5 cycles -> redirect_valid and redirect_pc stable for 5 cycles, and a branch presented meanwhile is not counted.
REQ-047 funct3=010, pred=0 -> res_illegal=1, res_taken=0, no redirect.
REQ-048 rst pulsed in the second FLUSH cycle -> all outputs 0 at once, counters 0, ex_ready=1 after release.
